// File: rtl/mux21_pkg.sv
// rtl/mux21_pkg.sv - shared select encoding for the codebase's 2:1 muxes
package mux21_pkg;

  typedef logic mux21_sel_t;

  localparam mux21_sel_t SEL_INPUT1 = 1'b0;
  localparam mux21_sel_t SEL_INPUT2 = 1'b1;

  function automatic mux21_sel_t mux21_other(input mux21_sel_t sel);
    return ~sel;
  endfunction

endpackage

// File: rtl/mux21_rr_grant.sv
// rtl/mux21_rr_grant.sv - combinational two-way grant with priority and packet-lock owner
module mux21_rr_grant
  import mux21_pkg::*;
(
  input  logic       valid1_i,
  input  logic       valid2_i,
  input  mux21_sel_t prio_i,
  input  logic       locked_i,
  input  mux21_sel_t owner_i,
  output logic       grant_valid_o,
  output mux21_sel_t grant_o
);

  always_comb begin
    grant_valid_o = 1'b0;
    grant_o       = prio_i;
    if (locked_i) begin
      // A locked owner keeps the grant even when idle; the other input waits.
      grant_o       = owner_i;
      grant_valid_o = (owner_i == SEL_INPUT2) ? valid2_i : valid1_i;
    end else if (valid1_i && valid2_i) begin
      grant_o       = prio_i;
      grant_valid_o = 1'b1;
    end else if (valid1_i) begin
      grant_o       = SEL_INPUT1;
      grant_valid_o = 1'b1;
    end else if (valid2_i) begin
      grant_o       = SEL_INPUT2;
      grant_valid_o = 1'b1;
    end
  end

endmodule

// File: rtl/mux21_rr_arbiter.sv
// rtl/mux21_rr_arbiter.sv - round-robin 2:1 stream arbiter with registered output; MUX21_LOCK_EN enables packet lock
module mux21_rr_arbiter
  import mux21_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] input1_data,
  input  logic             input1_valid,
  input  logic             input1_last,
  output logic             input1_ready,
  input  logic [WIDTH-1:0] input2_data,
  input  logic             input2_valid,
  input  logic             input2_last,
  output logic             input2_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  output logic             out1_last,
  input  logic             out1_ready,
  output mux21_sel_t       select
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  mux21_sel_t       sel_q, sel_d;
  mux21_sel_t       prio_q, prio_d;
  logic             lock_active;

  logic             space;
  logic             accept;
  logic             grant_valid;
  mux21_sel_t       grant;
  logic [WIDTH-1:0] win_data;
  logic             win_last;

`ifdef MUX21_LOCK_EN
  logic locked_q, locked_d;
  assign lock_active = locked_q;
`else
  assign lock_active = 1'b0;
`endif

  // While locked, the owner is always the source of the last accepted beat.
  mux21_rr_grant u_grant (
    .valid1_i      (input1_valid),
    .valid2_i      (input2_valid),
    .prio_i        (prio_q),
    .locked_i      (lock_active),
    .owner_i       (sel_q),
    .grant_valid_o (grant_valid),
    .grant_o       (grant)
  );

  assign space    = ~valid_q | out1_ready;
  assign accept   = grant_valid & space & ~rst;
  assign win_data = (grant == SEL_INPUT2) ? input2_data : input1_data;
  assign win_last = (grant == SEL_INPUT2) ? input2_last : input1_last;

  assign input1_ready = accept & (grant == SEL_INPUT1);
  assign input2_ready = accept & (grant == SEL_INPUT2);

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    sel_d   = sel_q;
    prio_d  = prio_q;
`ifdef MUX21_LOCK_EN
    locked_d = locked_q;
`endif
    if (accept) begin
      data_d  = win_data;
      last_d  = win_last;
      sel_d   = grant;
      valid_d = 1'b1;
`ifdef MUX21_LOCK_EN
      if (win_last) begin
        prio_d   = mux21_other(grant);
        locked_d = 1'b0;
      end else begin
        locked_d = 1'b1;
      end
`else
      prio_d = mux21_other(grant);
`endif
    end else if (out1_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      sel_q   <= SEL_INPUT1;
      prio_q  <= SEL_INPUT1;
`ifdef MUX21_LOCK_EN
      locked_q <= 1'b0;
`endif
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      prio_q  <= prio_d;
`ifdef MUX21_LOCK_EN
      locked_q <= locked_d;
`endif
    end
  end

  assign out1_data  = data_q;
  assign out1_valid = valid_q;
  assign out1_last  = last_q;
  assign select     = sel_q;

endmodule

// File: tb/tb_mux21_rr_arbiter.sv
// tb/tb_mux21_rr_arbiter.sv - self-checking bench for mux21_rr_arbiter against a beat-level reference model
module tb_mux21_rr_arbiter;

  localparam int WIDTH = 8;
`ifdef MUX21_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] input1_data, input2_data, out1_data;
  logic             input1_valid, input1_last, input1_ready;
  logic             input2_valid, input2_last, input2_ready;
  logic             out1_valid, out1_last, out1_ready;
  logic             select;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: arbitration owner, preference and the output beat.
  bit             m_prio, m_locked, m_owner, m_valid, m_last, m_sel;
  logic [WIDTH-1:0] m_data;
  bit             er1, er2;

  mux21_rr_arbiter #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .input1_data  (input1_data),
    .input1_valid (input1_valid),
    .input1_last  (input1_last),
    .input1_ready (input1_ready),
    .input2_data  (input2_data),
    .input2_valid (input2_valid),
    .input2_last  (input2_last),
    .input2_ready (input2_ready),
    .out1_data    (out1_data),
    .out1_valid   (out1_valid),
    .out1_last    (out1_last),
    .out1_ready   (out1_ready),
    .select       (select)
  );

  always #5 clk = ~clk;

  function automatic void model_eval();
    bit space;
    space = !m_valid || out1_ready;
    er1 = 1'b0;
    er2 = 1'b0;
    if (!rst && space) begin
      if (m_locked) begin
        if (m_owner) er2 = input2_valid;
        else         er1 = input1_valid;
      end else if (input1_valid && input2_valid) begin
        if (m_prio) er2 = 1'b1;
        else        er1 = 1'b1;
      end else begin
        er1 = input1_valid;
        er2 = input2_valid;
      end
    end
  endfunction

  function automatic void model_commit();
    bit src;
    if (rst) begin
      m_prio = 0; m_locked = 0; m_owner = 0;
      m_valid = 0; m_last = 0; m_sel = 0; m_data = '0;
    end else if (er1 || er2) begin
      src     = er2;
      m_data  = src ? input2_data : input1_data;
      m_last  = src ? input2_last : input1_last;
      m_sel   = src;
      m_valid = 1;
      if (LOCK_EN) begin
        if (m_last) begin
          m_locked = 0;
          m_prio   = !src;
        end else begin
          m_locked = 1;
          m_owner  = src;
        end
      end else begin
        m_prio = !src;
      end
    end else if (out1_ready) begin
      m_valid = 0;
    end
  endfunction

  task automatic adv();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    input1_valid = 1'b0;
    input2_valid = 1'b0;
    @(negedge clk);
    model_eval();
    adv();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    input1_valid = 1'b1; input2_valid = 1'b1;
    input1_data = 8'h5A; input2_data = 8'hA5;
    input1_last = 1'b1; input2_last = 1'b1;
    out1_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      model_eval();
      n_total++;
      if ({input1_ready, input2_ready} !== 2'b00)
        $display("FAIL reset_ready cyc%0d got %b%b want 00", i, input1_ready, input2_ready);
      else n_pass++;
      if (i == 1) begin
        n_total++;
        if ({out1_valid, out1_data, out1_last, select} !== 11'd0)
          $display("FAIL reset_out got v%b d%h l%b s%b want all 0", out1_valid, out1_data, out1_last, select);
        else n_pass++;
      end
      adv();
    end
    rst = 1'b0;
    input1_valid = 1'b0; input2_valid = 1'b0;
    @(negedge clk);
    model_eval();
    n_total++;
    if ({out1_valid, out1_data, out1_last, select} !== 11'd0)
      $display("FAIL after_reset_out got v%b d%h l%b s%b want all 0", out1_valid, out1_data, out1_last, select);
    else n_pass++;
    adv();
  endtask

  task automatic test_contention();
    apply_reset();
    input1_valid = 1'b1; input2_valid = 1'b1;
    input1_data = 8'h11; input2_data = 8'h22;
    input1_last = 1'b1; input2_last = 1'b1;
    out1_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      model_eval();
      n_total++;
      if ({input1_ready, input2_ready} !== {er1, er2})
        $display("FAIL contention_ready cyc%0d got %b%b want %b%b", i, input1_ready, input2_ready, er1, er2);
      else n_pass++;
      if (i >= 1) begin
        n_total++;
        if ({out1_valid, out1_data, select} !== {1'b1, (i % 2 == 1) ? 8'h11 : 8'h22, (i % 2 == 0)})
          $display("FAIL contention_out cyc%0d got v%b d%h s%b want v1 d%h s%0d",
                   i, out1_valid, out1_data, select, (i % 2 == 1) ? 8'h11 : 8'h22, (i % 2 == 0));
        else n_pass++;
      end
      adv();
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    input1_valid = 1'b1; input2_valid = 1'b1;
    input1_data = 8'h11; input2_data = 8'h22;
    input1_last = 1'b1; input2_last = 1'b1;
    out1_ready = 1'b1;
    @(negedge clk);
    model_eval();
    adv();
    out1_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      model_eval();
      n_total++;
      if ({out1_valid, out1_data, input1_ready, input2_ready} !== {1'b1, 8'h11, 2'b00})
        $display("FAIL backpressure_hold cyc%0d got v%b d%h r%b%b want v1 d11 r00",
                 i, out1_valid, out1_data, input1_ready, input2_ready);
      else n_pass++;
      adv();
    end
    out1_ready = 1'b1;
    @(negedge clk);
    model_eval();
    n_total++;
    if ({input1_ready, input2_ready} !== 2'b01)
      $display("FAIL backpressure_release_ready got %b%b want 01", input1_ready, input2_ready);
    else n_pass++;
    adv();
    @(negedge clk);
    model_eval();
    n_total++;
    if ({out1_valid, out1_data, select} !== {1'b1, 8'h22, 1'b1})
      $display("FAIL backpressure_next got v%b d%h s%b want v1 d22 s1", out1_valid, out1_data, select);
    else n_pass++;
    adv();
  endtask

  task automatic test_single();
    apply_reset();
    input1_valid = 1'b0;
    input2_last = 1'b1;
    out1_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      input2_valid = (i < 5);
      input2_data  = 8'(i + 1);
      @(negedge clk);
      model_eval();
      if (i >= 1) begin
        n_total++;
        if ({out1_valid, out1_data, select} !== {1'b1, 8'(i), 1'b1})
          $display("FAIL single_out beat%0d got v%b d%h s%b want v1 d%h s1", i, out1_valid, out1_data, select, 8'(i));
        else n_pass++;
      end
      adv();
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      rst          = ($urandom_range(0, 49) == 0);
      input1_valid = $urandom_range(0, 1);
      input2_valid = $urandom_range(0, 1);
      input1_data  = 8'($urandom);
      input2_data  = 8'($urandom);
      input1_last  = ($urandom_range(0, 2) == 0);
      input2_last  = ($urandom_range(0, 2) == 0);
      out1_ready   = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      model_eval();
      n_total++;
      if ({input1_ready, input2_ready} !== {er1, er2})
        $display("FAIL random_ready cyc%0d got %b%b want %b%b", i, input1_ready, input2_ready, er1, er2);
      else n_pass++;
      n_total++;
      if ({out1_valid, out1_data, out1_last, select} !== {m_valid, m_data, m_last, m_sel})
        $display("FAIL random_out cyc%0d got v%b d%h l%b s%b want v%b d%h l%b s%b", i,
                 out1_valid, out1_data, out1_last, select, m_valid, m_data, m_last, m_sel);
      else n_pass++;
      adv();
    end
    rst = 1'b0;
  endtask

`ifdef MUX21_LOCK_EN
  task automatic test_lock();
    logic [7:0] exp_d [1:5];
    logic       exp_l [1:5];
    logic       exp_s [1:5];
    int b;
    exp_d = '{8'h10, 8'hA1, 8'hA2, 8'hA3, 8'h22};
    exp_l = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    apply_reset();
    out1_ready  = 1'b1;
    input2_data = 8'h22;
    input2_last = 1'b1;
    b = 0;
    for (int i = 0; i < 6; i++) begin
      input1_valid = (b < 4);
      input1_data  = (b == 0) ? 8'h10 : 8'(8'hA0 + b);
      input1_last  = (b == 0) || (b == 3);
      input2_valid = (i >= 2);
      @(negedge clk);
      model_eval();
      if (i >= 1) begin
        n_total++;
        if ({out1_valid, out1_data, out1_last, select} !== {1'b1, exp_d[i], exp_l[i], exp_s[i]})
          $display("FAIL lock_out cyc%0d got v%b d%h l%b s%b want v1 d%h l%b s%b", i,
                   out1_valid, out1_data, out1_last, select, exp_d[i], exp_l[i], exp_s[i]);
        else n_pass++;
      end
      if (input1_ready) b++;
      adv();
    end
  endtask
`endif

  task automatic test_mid_reset();
    apply_reset();
    out1_ready = 1'b1;
    input1_valid = 1'b1; input1_data = 8'h10; input1_last = 1'b1;
    input2_valid = 1'b0;
    @(negedge clk); model_eval(); adv();
    input1_valid = 1'b0;
    input2_valid = 1'b1; input2_data = 8'h31; input2_last = 1'b0;
    @(negedge clk); model_eval(); adv();
    rst = 1'b1;
    @(negedge clk); model_eval(); adv();
    rst = 1'b0;
    input1_valid = 1'b1; input1_data = 8'h41; input1_last = 1'b1;
    input2_data = 8'h32;
    @(negedge clk);
    model_eval();
    n_total++;
    if ({input1_ready, input2_ready} !== 2'b10)
      $display("FAIL midreset_ready got %b%b want 10", input1_ready, input2_ready);
    else n_pass++;
    adv();
    @(negedge clk);
    model_eval();
    n_total++;
    if ({out1_valid, out1_data, select} !== {1'b1, 8'h41, 1'b0})
      $display("FAIL midreset_out got v%b d%h s%b want v1 d41 s0", out1_valid, out1_data, select);
    else n_pass++;
    adv();
  endtask

  initial begin
    rst = 1'b1;
    input1_valid = 1'b0; input2_valid = 1'b0;
    input1_data = '0; input2_data = '0;
    input1_last = 1'b0; input2_last = 1'b0;
    out1_ready = 1'b0;
    m_prio = 0; m_locked = 0; m_owner = 0; m_valid = 0; m_last = 0; m_sel = 0; m_data = '0;
    er1 = 0; er2 = 0;
    #1;
    test_reset();
    test_contention();
    test_backpressure();
    test_single();
    test_random();
`ifdef MUX21_LOCK_EN
    test_lock();
`endif
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
